// File: rtl/wb_usbdev_regfifo_if.sv
// Wishbone classic bus bundle between the pin-to-wishbone master and the USB register block.
// Latency: none, wires only.
// Backpressure: the slave stalls the master by withholding wb_ACK.
interface wb_usbdev_regfifo_if;
  logic        wb_CYC;
  logic        wb_STB;
  logic        wb_WE;
  logic [13:0] wb_ADR;
  logic [31:0] wb_DAT_MOSI;
  logic [3:0]  wb_SEL;
  logic        wb_ACK;
  logic [31:0] wb_DAT_MISO;

  modport master (
    output wb_CYC, wb_STB, wb_WE, wb_ADR, wb_DAT_MOSI, wb_SEL,
    input  wb_ACK, wb_DAT_MISO
  );

  modport slave (
    input  wb_CYC, wb_STB, wb_WE, wb_ADR, wb_DAT_MOSI, wb_SEL,
    output wb_ACK, wb_DAT_MISO
  );
endinterface

// File: rtl/wb_usbdev_regfifo.sv
// Byte FIFO with flush, simultaneous push/pop when full, and an overflow strobe.
// Latency: a pushed byte is visible at head one cycle after the push edge.
// Backpressure: none; a push into a full FIFO without a same-cycle pop is dropped and flagged.
module wb_usbdev_regfifo_fifo #(
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [7:0]    push_dat,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic          ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;

  // Next pointers/level; a pop frees the slot a same-cycle push needs, flush overrides everything.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    ovf      = push && full && !do_pop && !flush;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      level_d = level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

// Wishbone classic slave: ID/CTRL/STATUS/SCRATCH registers plus TX and RX byte FIFOs.
// Latency: wb_ACK rises 1+WAIT_STATES cycles after STB is first sampled; all side effects land on that edge.
// Backpressure: the bus is stalled by wait states only; TX drains on tx_valid&tx_ready, RX never stalls.
module wb_usbdev_regfifo #(
  parameter int          WAIT_STATES = 1,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] ID_VALUE    = 32'h55534231
) (
  input  logic                       clk,
  input  logic                       rst,
  wb_usbdev_regfifo_if.slave         wb,
  output logic                       usb_enable,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid
);
  localparam int          LW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0]  CNT_END = 3'(WAIT_STATES);

  localparam logic [13:0] A_ID      = 14'h000;
  localparam logic [13:0] A_CTRL    = 14'h001;
  localparam logic [13:0] A_STATUS  = 14'h002;
  localparam logic [13:0] A_SCRATCH = 14'h003;
  localparam logic [13:0] A_TXDATA  = 14'h004;
  localparam logic [13:0] A_RXDATA  = 14'h005;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          lockout_q, lockout_d;
  logic          do_ack;

  logic          enable_q, enable_d;
  logic [31:0]   scratch_q, scratch_d;
  logic          tx_ovf_q, tx_ovf_d;
  logic          rx_ovf_q, rx_ovf_d;
  logic          bus_err_q, bus_err_d;
  logic [31:0]   dat_miso_q, dat_miso_d;

  logic          wr_en, rd_en, flush, tx_push, tx_pop, rx_pop, bus_err_ev;
  logic          tx_full, tx_empty, tx_ovf_ev;
  logic          rx_full, rx_empty, rx_ovf_ev;
  logic [7:0]    rx_head;
  logic [LW-1:0] tx_level, rx_level;
  logic [31:0]   status_w, rd_data;
  logic          unused_sel;

  // Only lane 0 gates writes; the upper lanes carry no meaning here.
  assign unused_sel = ^wb.wb_SEL[3:1];

  // Transaction strobes, all qualified by the edge that raises wb_ACK.
  assign wr_en      = do_ack && wb.wb_WE && wb.wb_SEL[0];
  assign rd_en      = do_ack && !wb.wb_WE;
  assign flush      = wr_en && (wb.wb_ADR == A_CTRL) && wb.wb_DAT_MOSI[1];
  assign tx_push    = wr_en && (wb.wb_ADR == A_TXDATA);
  assign rx_pop     = rd_en && (wb.wb_ADR == A_RXDATA);
  assign tx_pop     = tx_valid && tx_ready;
  assign bus_err_ev = do_ack && (wb.wb_ADR > A_RXDATA);

  wb_usbdev_regfifo_fifo #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_tx_fifo (
    .clk(clk), .rst(rst), .flush(flush),
    .push(tx_push), .push_dat(wb.wb_DAT_MOSI[7:0]), .pop(tx_pop),
    .head(tx_data), .level(tx_level), .full(tx_full), .empty(tx_empty), .ovf(tx_ovf_ev)
  );

  wb_usbdev_regfifo_fifo #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_rx_fifo (
    .clk(clk), .rst(rst), .flush(flush),
    .push(rx_valid), .push_dat(rx_data), .pop(rx_pop),
    .head(rx_head), .level(rx_level), .full(rx_full), .empty(rx_empty), .ovf(rx_ovf_ev)
  );

  assign tx_valid        = !tx_empty;
  assign usb_enable      = enable_q;
  assign wb.wb_ACK       = (state_q == S_ACK);
  assign wb.wb_DAT_MISO  = dat_miso_q;

  assign status_w = {16'h0, 4'(rx_level), 4'(tx_level), 1'b0, bus_err_q, rx_ovf_q, tx_ovf_q,
                     rx_empty, rx_full, tx_empty, tx_full};

  // Handshake FSM: wait-state count, one-cycle ACK, then hold off until the master drops STB.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lockout_d = lockout_q;
    do_ack    = 1'b0;
    if (!(wb.wb_CYC && wb.wb_STB)) begin
      lockout_d = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (wb.wb_CYC && wb.wb_STB && !lockout_q) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!wb.wb_CYC) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_END) begin
          state_d   = S_ACK;
          do_ack    = 1'b1;
          lockout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_ACK: begin
        state_d = wb.wb_CYC ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!wb.wb_CYC || !wb.wb_STB) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read mux: values as they stand before the ACK edge.
  always_comb begin
    rd_data = '0;
    case (wb.wb_ADR)
      A_ID:      rd_data = ID_VALUE;
      A_CTRL:    rd_data = {31'h0, enable_q};
      A_STATUS:  rd_data = status_w;
      A_SCRATCH: rd_data = scratch_q;
      A_RXDATA:  rd_data = rx_empty ? 32'h100 : {24'h0, rx_head};
      default:   rd_data = '0;
    endcase
  end

  // Register writes, W1C clears and sticky flags; a new event outranks a same-cycle clear.
  always_comb begin
    enable_d   = enable_q;
    scratch_d  = scratch_q;
    tx_ovf_d   = tx_ovf_q;
    rx_ovf_d   = rx_ovf_q;
    bus_err_d  = bus_err_q;
    dat_miso_d = dat_miso_q;
    if (wr_en) begin
      case (wb.wb_ADR)
        A_CTRL:    enable_d  = wb.wb_DAT_MOSI[0];
        A_SCRATCH: scratch_d = wb.wb_DAT_MOSI;
        A_STATUS: begin
          if (wb.wb_DAT_MOSI[4]) tx_ovf_d  = 1'b0;
          if (wb.wb_DAT_MOSI[5]) rx_ovf_d  = 1'b0;
          if (wb.wb_DAT_MOSI[6]) bus_err_d = 1'b0;
        end
        default: ;
      endcase
    end
    if (tx_ovf_ev)  tx_ovf_d  = 1'b1;
    if (rx_ovf_ev)  rx_ovf_d  = 1'b1;
    if (bus_err_ev) bus_err_d = 1'b1;
    if (do_ack) begin
      dat_miso_d = wb.wb_WE ? 32'h0 : rd_data;
    end
  end

  // State and register file flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lockout_q  <= 1'b0;
      enable_q   <= 1'b0;
      scratch_q  <= '0;
      tx_ovf_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
      bus_err_q  <= 1'b0;
      dat_miso_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lockout_q  <= lockout_d;
      enable_q   <= enable_d;
      scratch_q  <= scratch_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ovf_q   <= rx_ovf_d;
      bus_err_q  <= bus_err_d;
      dat_miso_q <= dat_miso_d;
    end
  end
endmodule

// File: doc/wb_usbdev_regfifo.md
Name: wb_usbdev_regfifo

Overview:
- Wishbone classic slave that sits directly downstream of the TT pin-to-wishbone master and consumes its CYC/STB/WE/ADR/DAT/SEL transactions.
- Provides an ID register, control, status and scratch registers.
- Provides an 8-bit TX FIFO (CPU→USB core) and an 8-bit RX FIFO (USB core→CPU).
- ACK is generated after a programmable number of wait states.

Parameters:
- WAIT_STATES, 1, idle cycles between STB sampled high and ACK asserted (0..7).
- FIFO_DEPTH, 8, entries per FIFO; power of two, 2..8.
- ID_VALUE, 32'h55534231, value returned by the ID register.

Ports:
- clk  in  1  single system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- wb_CYC  in  1  bus cycle
- wb_STB  in  1  strobe
- wb_WE  in  1  write enable
- wb_ADR  in  14  32-bit word address
- wb_DAT_MOSI  in  32  write data
- wb_SEL  in  4  byte lanes; lane 0 must be set for a write to take effect
- wb_ACK  out  1  one-cycle acknowledge
- wb_DAT_MISO  out  32  read data, valid while wb_ACK=1
- usb_enable  out  1  CTRL[0]
- tx_data  out  8  TX FIFO head
- tx_valid  out  1  TX FIFO not empty
- tx_ready  in  1  USB core consumes head when tx_valid&tx_ready
- rx_data  in  8  byte from USB core
- rx_valid  in  1  push rx_data into RX FIFO (no backpressure)

Behaviour:
- Reset (rst=1 at clk edge):
  - wb_ACK=0, wb_DAT_MISO=0, CTRL=0 so usb_enable=0, SCRATCH=0.
  - Both FIFOs empty, sticky flags clear, wait counter=0, lockout=0.
  - A transaction in flight is abandoned without ACK; the master must retry.
- Handshake FSM states: IDLE, WAIT, ACK, HOLD.
  - IDLE → WAIT when CYC&STB&!lockout.
  - In WAIT, the counter runs from 0; when counter==WAIT_STATES, go to ACK. With WAIT_STATES=0, ACK follows IDLE by exactly 1 cycle, so the first ACK is 1+WAIT_STATES cycles after STB is first sampled.
  - In ACK: wb_ACK=1 for exactly one cycle. Register writes, FIFO push/pop and wb_DAT_MISO capture all take effect at the edge that raises wb_ACK.
  - ACK → HOLD. HOLD → IDLE once STB=0 or CYC=0; an ACK is never repeated for a held STB.
  - Any state → IDLE if CYC drops, with no side effects unless ACK was already issued.
- Address map (word addresses):
  - 0x000 ID, RO: ID_VALUE.
  - 0x001 CTRL, RW, bits [1:0]:
    - bit0 enable.
    - bit1 flush: write-1 empties both FIFOs at the ACK edge; always reads 0.
  - 0x002 STATUS, RO except W1C on bits [6:4]:
    - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty.
    - [4] tx_ovf, [5] rx_ovf, [6] bus_err (all sticky).
    - [11:8] tx_level, [15:12] rx_level.
  - 0x003 SCRATCH, RW, 32 bits.
  - 0x004 TXDATA, WO: push DAT[7:0]. If the FIFO is full, drop the byte and set tx_ovf. Reads return 0.
  - 0x005 RXDATA, RO: pop and return {23'b0, 1'b0, byte}. If the FIFO is empty, return 32'h100 with no pop. Writes are ignored.
  - Any other address: reads return 0, writes are ignored, ACK is still given, and bus_err is set.
- Width/arithmetic:
  - FIFO pointers wrap modulo FIFO_DEPTH.
  - Level is log2(FIFO_DEPTH)+1 bits, zero-extended into its 4-bit status field.
- Simultaneous events:
  - TX FIFO full with a consumer pop and a CPU push in the same cycle: both succeed, level unchanged, no tx_ovf.
  - RX FIFO full with a CPU pop and an rx_valid push in the same cycle: both succeed, no rx_ovf.
  - rx_valid while the RX FIFO is full with no pop: byte dropped, rx_ovf set.
  - Flush together with any push or pop: flush wins and the FIFOs end empty.
  - W1C clear in the same cycle as a new overflow event: set wins.
  - A write with wb_SEL[0]=0 is acknowledged with no side effects.

Test Plan:
- Reset, then read 0x000 with WAIT_STATES=1 → ACK exactly 2 cycles after STB is sampled, DAT=32'h55534231, ACK high for 1 cycle only; hold STB 3 more cycles → no second ACK.
- Write SCRATCH=32'hDEADBEEF, read back → 32'hDEADBEEF; write CTRL=1 → usb_enable=1 after the ACK edge.
- Push 0x11,0x22,…,0x88 to TXDATA with tx_ready=0 → STATUS[0]=1, [11:8]=8; 9th push → tx_ovf=1; set tx_ready=1 → tx_data order 0x11..0x88, then tx_valid=0.
- Pulse rx_valid with 0xA5 then 0x5A; read RXDATA ×3 → 0xA5, 0x5A, 32'h100; rx_level returns to 0.
- Fill the RX FIFO and pulse rx_valid → rx_ovf=1; write STATUS=0x70 → flags cleared; repeat with an overflow in the same cycle as the W1C → flag stays 1.
- Read 0x3FFF → DAT=0, bus_err=1. Assert rst during WAIT of a TXDATA write → no ACK, tx_level=0, all outputs at reset values.
